fp32_to_int32_conv: RTL and testbench

FP32_TO_INT32_CONV -- requirements
Module: fp32_to_int32_conv

---
 rtl/fp32_to_int32_conv.sv | 174 +++++++++++++++++
 tb/tb_fp32_to_int32_conv.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32_conv.sv
// Multi-cycle IEEE-754 binary32 to int32/uint32 converter with a strobe/busy handshake.
// Rounds toward zero; the magnitude is aligned one bit per cycle.
module fp32_to_int32_conv #(
    parameter int unsigned SIGNED_OUT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_z,
    input  logic        conv_input_STB,
    output logic        conv_BUSY,
    output logic [31:0] output_int,
    output logic        output_invalid,
    output logic        conv_output_STB,
    input  logic        output_module_BUSY
);

    localparam bit Signed = (SIGNED_OUT != 0);

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StSpecial,
        StShift,
        StPack,
        StPut
    } state_e;

    state_e             state_q;
    logic [31:0]        operand_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        mant_q;
    logic [31:0]        mag_q;
    logic [4:0]         cnt_q;
    logic               left_q;
    logic [31:0]        result_q;
    logic               invalid_q;
    logic               busy_q;
    logic               stb_q;
    logic [31:0]        out_int_q;
    logic               out_inv_q;

    logic [7:0]  raw_exp;
    logic        is_nan;
    logic        is_tiny;
    logic        shift_left;
    logic [4:0]  shift_amt;
    logic        spec_take;
    logic [31:0] spec_res;
    logic        spec_inv;

    // Classification of the unpacked operand, consumed in StSpecial.
    always_comb begin
        raw_exp    = operand_q[30:23];
        is_nan     = (raw_exp == 8'hFF) && (operand_q[22:0] != 23'd0);
        is_tiny    = (raw_exp == 8'h00) || (exp_q < 10'sd0);
        shift_left = (exp_q > 10'sd23);
        // In-range exponents are 0..31, so five bits of e carry the full distance.
        shift_amt  = shift_left ? (exp_q[4:0] - 5'd23) : (5'd23 - exp_q[4:0]);
    end

    always_comb begin
        spec_take = 1'b1;
        spec_res  = 32'h0000_0000;
        spec_inv  = 1'b0;
        if (is_nan) begin
            spec_res = Signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            spec_inv = 1'b1;
        end else if (is_tiny) begin
            spec_res = 32'h0000_0000;
        end else if (Signed) begin
            if (exp_q >= 10'sd31) begin
                // -2^31 is the only e>=31 value that is representable.
                if (operand_q == 32'hCF00_0000) begin
                    spec_res = 32'h8000_0000;
                end else begin
                    spec_res = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    spec_inv = 1'b1;
                end
            end else begin
                spec_take = 1'b0;
            end
        end else begin
            if (sign_q) begin
                spec_inv = 1'b1;
            end else if (exp_q >= 10'sd32) begin
                spec_res = 32'hFFFF_FFFF;
                spec_inv = 1'b1;
            end else begin
                spec_take = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            operand_q <= 32'h0000_0000;
            sign_q    <= 1'b0;
            exp_q     <= 10'sd0;
            mant_q    <= 24'h00_0000;
            mag_q     <= 32'h0000_0000;
            cnt_q     <= 5'd0;
            left_q    <= 1'b0;
            result_q  <= 32'h0000_0000;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            stb_q     <= 1'b0;
            out_int_q <= 32'h0000_0000;
            out_inv_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    if (!busy_q && conv_input_STB) begin
                        operand_q <= input_z;
                        busy_q    <= 1'b1;
                        state_q   <= StUnpack;
                    end
                end
                StUnpack: begin
                    sign_q  <= operand_q[31];
                    exp_q   <= $signed({2'b00, operand_q[30:23]}) - 10'sd127;
                    mant_q  <= {1'b1, operand_q[22:0]};
                    state_q <= StSpecial;
                end
                StSpecial: begin
                    if (spec_take) begin
                        result_q  <= spec_res;
                        invalid_q <= spec_inv;
                        state_q   <= StPut;
                    end else begin
                        mag_q   <= {8'h00, mant_q};
                        cnt_q   <= shift_amt;
                        left_q  <= shift_left;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (cnt_q != 5'd0) begin
                        mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
                        cnt_q <= cnt_q - 5'd1;
                    end else begin
                        state_q <= StPack;
                    end
                end
                StPack: begin
                    result_q  <= (Signed && sign_q) ? (~mag_q + 32'd1) : mag_q;
                    invalid_q <= 1'b0;
                    state_q   <= StPut;
                end
                StPut: begin
                    if (!stb_q) begin
                        stb_q     <= 1'b1;
                        out_int_q <= result_q;
                        out_inv_q <= invalid_q;
                    end else if (!output_module_BUSY) begin
                        stb_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign conv_BUSY       = busy_q;
    assign conv_output_STB = stb_q;
    assign output_int      = out_int_q;
    assign output_invalid  = out_inv_q;

endmodule

// File: tb/tb_fp32_to_int32_conv.sv
// Directed bench for fp32_to_int32_conv: signed and unsigned instances, latency,
// special operands, downstream back-pressure and asynchronous reset mid-conversion.
module tb_fp32_to_int32_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] input_z = 32'h0;
    logic        stb_s = 1'b0;
    logic        stb_u = 1'b0;
    logic        ds_busy = 1'b0;

    logic        busy_s, busy_u;
    logic [31:0] int_s, int_u;
    logic        inv_s, inv_u;
    logic        ostb_s, ostb_u;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] op;
        int          lat;
        logic [31:0] res;
        logic        inv;
    } vec_t;

    always #5 clk = ~clk;

    fp32_to_int32_conv #(.SIGNED_OUT(1)) dut_s (
        .clk                (clk),
        .rst                (rst),
        .input_z            (input_z),
        .conv_input_STB     (stb_s),
        .conv_BUSY          (busy_s),
        .output_int         (int_s),
        .output_invalid     (inv_s),
        .conv_output_STB    (ostb_s),
        .output_module_BUSY (ds_busy)
    );

    fp32_to_int32_conv #(.SIGNED_OUT(0)) dut_u (
        .clk                (clk),
        .rst                (rst),
        .input_z            (input_z),
        .conv_input_STB     (stb_u),
        .conv_BUSY          (busy_u),
        .output_int         (int_u),
        .output_invalid     (inv_u),
        .conv_output_STB    (ostb_u),
        .output_module_BUSY (ds_busy)
    );

    // Drives one operand and reports the edge (accepting edge = 0) at which the strobe rose.
    task automatic run_op(input bit uns, input logic [31:0] op, output int edges,
                          output logic [31:0] res, output logic inv);
        @(negedge clk);
        input_z = op;
        if (uns) stb_u = 1'b1;
        else     stb_s = 1'b1;
        @(posedge clk);
        #1;
        stb_s = 1'b0;
        stb_u = 1'b0;
        edges = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if ((uns ? ostb_u : ostb_s) === 1'b1) begin
                edges = i;
                break;
            end
        end
        res = uns ? int_u : int_s;
        inv = uns ? inv_u : inv_s;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy_s, ostb_s, int_s, inv_s, busy_u, ostb_u, int_u, inv_u} !== 70'd0) begin
            failures++;
            $display("FAIL reset_state: got s=%b/%b/%h/%b u=%b/%b/%h/%b want all zero",
                     busy_s, ostb_s, int_s, inv_s, busy_u, ostb_u, int_u, inv_u);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_table(input bit uns, input string tag, input vec_t v);
        int          e;
        logic [31:0] r;
        logic        iv;
        run_op(uns, v.op, e, r, iv);
        checks++;
        if (e !== v.lat || r !== v.res || iv !== v.inv) begin
            failures++;
            $display("FAIL %s op=%h: got edge=%0d int=%h inv=%b, want edge=%0d int=%h inv=%b",
                     tag, v.op, e, r, iv, v.lat, v.res, v.inv);
        end
    endtask

    task automatic test_signed_range();
        vec_t v [7];
        v = '{'{32'h3F80_0000, 28, 32'h0000_0001, 1'b0},
              '{32'h4B00_0000,  5, 32'h0080_0000, 1'b0},
              '{32'hC2F6_E979, 22, 32'hFFFF_FF85, 1'b0},
              '{32'h4EFF_FFFF, 12, 32'h7FFF_FF80, 1'b0},
              '{32'h4020_0000, 27, 32'h0000_0002, 1'b0},
              '{32'hC020_0000, 27, 32'hFFFF_FFFE, 1'b0},
              '{32'h4040_0000, 27, 32'h0000_0003, 1'b0}};
        foreach (v[i]) run_table(1'b0, "signed_range", v[i]);
    endtask

    task automatic test_signed_special();
        vec_t v [7];
        v = '{'{32'h7FC0_0000, 3, 32'h7FFF_FFFF, 1'b1},
              '{32'hFF80_0000, 3, 32'h8000_0000, 1'b1},
              '{32'hCF00_0000, 3, 32'h8000_0000, 1'b0},
              '{32'h4F00_0000, 3, 32'h7FFF_FFFF, 1'b1},
              '{32'h3F7F_FFFF, 3, 32'h0000_0000, 1'b0},
              '{32'h0000_0001, 3, 32'h0000_0000, 1'b0},
              '{32'h8000_0000, 3, 32'h0000_0000, 1'b0}};
        foreach (v[i]) run_table(1'b0, "signed_special", v[i]);
    endtask

    task automatic test_unsigned();
        vec_t v [6];
        v = '{'{32'hBF80_0000,  3, 32'h0000_0000, 1'b1},
              '{32'h4F80_0000,  3, 32'hFFFF_FFFF, 1'b1},
              '{32'hBF00_0000,  3, 32'h0000_0000, 1'b0},
              '{32'h4F7F_FFFF, 13, 32'hFFFF_FF00, 1'b0},
              '{32'h4F00_0000, 13, 32'h8000_0000, 1'b0},
              '{32'h7FC0_0000,  3, 32'hFFFF_FFFF, 1'b1}};
        foreach (v[i]) run_table(1'b1, "unsigned", v[i]);
    endtask

    task automatic test_backpressure();
        int e;
        @(negedge clk);
        ds_busy = 1'b1;
        input_z = 32'h4040_0000;
        stb_s   = 1'b1;
        @(posedge clk);
        #1;
        // Strobe stays high with a different operand; it must be ignored until idle.
        input_z = 32'h40A0_0000;
        e = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (ostb_s === 1'b1) begin
                e = i;
                break;
            end
        end
        checks++;
        if (e !== 27 || int_s !== 32'h3) begin
            failures++;
            $display("FAIL bp_first: got edge=%0d int=%h want edge=27 int=00000003", e, int_s);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ostb_s !== 1'b1 || int_s !== 32'h3 || inv_s !== 1'b0 || busy_s !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got stb=%b int=%h inv=%b busy=%b want 1/00000003/0/1",
                         i, ostb_s, int_s, inv_s, busy_s);
            end
        end
        @(negedge clk);
        ds_busy = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ostb_s !== 1'b0 || busy_s !== 1'b1 || int_s !== 32'h3) begin
            failures++;
            $display("FAIL bp_release: got stb=%b busy=%b int=%h want 0/1/00000003",
                     ostb_s, busy_s, int_s);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_s !== 1'b0) begin
            failures++;
            $display("FAIL bp_busy_fall: got busy=%b want 0", busy_s);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_s !== 1'b1) begin
            failures++;
            $display("FAIL bp_reaccept: got busy=%b want 1", busy_s);
        end
        stb_s = 1'b0;
        e = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (ostb_s === 1'b1) begin
                e = i;
                break;
            end
        end
        checks++;
        if (e !== 26 || int_s !== 32'h5 || inv_s !== 1'b0) begin
            failures++;
            $display("FAIL bp_second: got edge=%0d int=%h inv=%b want edge=26 int=00000005 inv=0",
                     e, int_s, inv_s);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_shift();
        int          e;
        logic [31:0] r;
        logic        iv;
        bit          saw_stb;
        @(negedge clk);
        input_z = 32'h3F80_0000;
        stb_s   = 1'b1;
        @(posedge clk);
        #1;
        stb_s = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        checks++;
        if (busy_s !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_busy: got busy=%b want 1", busy_s);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy_s !== 1'b0 || ostb_s !== 1'b0 || int_s !== 32'h0 || inv_s !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got busy=%b stb=%b int=%h inv=%b want 0/0/00000000/0",
                     busy_s, ostb_s, int_s, inv_s);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        saw_stb = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ostb_s !== 1'b0 || busy_s !== 1'b0) saw_stb = 1'b1;
        end
        checks++;
        if (saw_stb) begin
            failures++;
            $display("FAIL rst_abandon: got activity after reset, want none");
        end
        run_op(1'b0, 32'h4040_0000, e, r, iv);
        checks++;
        if (e !== 27 || r !== 32'h3 || iv !== 1'b0) begin
            failures++;
            $display("FAIL rst_after: got edge=%0d int=%h inv=%b want edge=27 int=00000003 inv=0",
                     e, r, iv);
        end
    endtask

    initial begin
        test_reset();
        test_signed_range();
        test_signed_special();
        test_unsigned();
        test_backpressure();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
